// File: rtl/mem_ctrl_pkg.sv
// Shared types and width helpers for the line-granular main-memory controller.
// Default geometry matches the cache line size used above this block.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RBURST,
    WBURST,
    DONE
  } state_t;

  localparam int unsigned DEF_LINE_WORDS = 4;
  localparam int unsigned DEF_LAT        = 8;

  function automatic int unsigned beat_width(int unsigned line_words);
    return (line_words > 1) ? $clog2(line_words) : 1;
  endfunction

  // Counter holds LAT-1 down to 0, so it needs clog2(LAT) bits.
  function automatic int unsigned cnt_width(int unsigned lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

  localparam int unsigned BEAT_W = beat_width(DEF_LINE_WORDS);
  localparam int unsigned CNT_W  = cnt_width(DEF_LAT);

endpackage

// File: rtl/mem_word_array.sv
// Single-port synchronous word RAM with one-cycle registered read.
// Contents are never reset; read returns the pre-write value on a write cycle.
module mem_word_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned DATA_W      = 32
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [DATA_W-1:0]              din,
  output logic [DATA_W-1:0]              dout
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/main_mem_ctrl.sv
// Main-memory controller below the cache: fixed-latency line fills and writebacks
// over a single-port word array.
module main_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned LINE_WORDS  = DEF_LINE_WORDS,
  parameter int unsigned LAT         = DEF_LAT,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wvalid,
  output logic              wready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              rlast,
  output logic              resp_done
);

  localparam int unsigned BW     = beat_width(LINE_WORDS);
  localparam int unsigned CW     = cnt_width(LAT);
  localparam int unsigned WAW    = $clog2(DEPTH_WORDS);
  localparam int unsigned LINE_W = WAW - BW;

  state_t              state, next;
  logic [CW-1:0]       cnt;
  logic [BW-1:0]       beat;
  logic [LINE_W-1:0]   line;
  logic                is_write;
  logic                ready_q;
  logic                accept;
  logic                beat_last;
  logic [WAW-1:0]      word_addr;
  logic [WAW-1:0]      ram_addr;
  logic                ram_we;
  logic [DATA_W-1:0]   ram_dout;
  logic                unused_addr_bits;

  // Byte offset and bits above the array are dropped: addresses wrap modulo depth.
  assign word_addr        = req_addr[WAW+1:2];
  assign unused_addr_bits = ^{req_addr[ADDR_W-1:WAW+2], req_addr[1:0]};

  assign accept    = req_valid && ready_q;
  assign beat_last = (beat == BW'(LINE_WORDS - 1));

  assign req_ready = ready_q;
  assign rvalid    = (state == RBURST);
  assign rlast     = rvalid && beat_last;
  assign wready    = (state == WBURST);
  assign resp_done = (state == DONE);
  assign rdata     = rvalid ? ram_dout : '0;
  assign ram_we    = wready && wvalid;

  always_comb begin
    next = state;
    unique case (state)
      IDLE:    if (accept) next = WAIT;
      WAIT:    if (cnt == '0) next = is_write ? WBURST : RBURST;
      RBURST:  if (beat_last) next = DONE;
      WBURST:  if (wvalid && beat_last) next = DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Reads are issued one cycle early so registered RAM output lines up with rvalid.
  always_comb begin
    ram_addr = {line, beat};
    unique case (state)
      WAIT:    ram_addr = {line, {BW{1'b0}}};
      RBURST:  ram_addr = {line, beat + BW'(1)};
      default: ram_addr = {line, beat};
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      beat     <= '0;
      line     <= '0;
      is_write <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state   <= next;
      ready_q <= (next == IDLE);
      unique case (state)
        IDLE: begin
          if (accept) begin
            cnt      <= CW'(LAT - 1);
            line     <= word_addr[WAW-1:BW];
            is_write <= req_we;
            beat     <= '0;
          end
        end
        WAIT:    if (cnt != '0) cnt <= cnt - CW'(1);
        RBURST:  beat <= beat + BW'(1);
        WBURST:  if (wvalid) beat <= beat + BW'(1);
        default: ;
      endcase
    end
  end

  mem_word_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .DATA_W     (DATA_W)
  ) u_array (
    .clk (clk),
    .we  (ram_we),
    .addr(ram_addr),
    .din (wdata),
    .dout(ram_dout)
  );

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Scoreboard bench for main_mem_ctrl: driver pushes expected beats/completions,
// a negedge monitor pops and compares them against a word-array reference model.
module tb_main_mem_ctrl;

  localparam int LW    = 4;
  localparam int LAT   = 8;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] wdata = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rlast;
  logic        resp_done;

  main_mem_ctrl #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .LINE_WORDS (LW),
    .LAT        (LAT),
    .DEPTH_WORDS(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .wdata    (wdata),
    .wvalid   (wvalid),
    .wready   (wready),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .rlast    (rlast),
    .resp_done(resp_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    bit          known;
    bit          last;
    int          at;
  } rexp_t;

  rexp_t rq[$];
  int    dq[$];

  logic [31:0] mdl   [DEPTH];
  bit          known [DEPTH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int line_base(input logic [31:0] addr);
    return ((int'(addr >> 2)) % DEPTH) & ~(LW - 1);
  endfunction

  // Monitor: every DUT output event is matched against the head of a queue.
  always @(negedge clk) begin
    if (rst) begin
      if (rvalid) begin
        if (rq.size() == 0) check("unexpected_rvalid", 1, 0);
        else begin
          rexp_t e;
          e = rq.pop_front();
          check("rbeat_cycle", 64'(cyc), 64'(e.at));
          if (e.known) check("rdata", rdata, e.data);
          check("rlast", rlast, e.last);
        end
      end else if (rlast) check("rlast_without_rvalid", 1, 0);
      if (resp_done) begin
        if (dq.size() == 0) check("unexpected_resp_done", 1, 0);
        else check("resp_done_cycle", 64'(cyc), 64'(dq.pop_front()));
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    req_valid = 1'b0;
    wvalid = 1'b0;
    rq.delete();
    dq.delete();
    repeat (3) begin
      @(negedge clk);
      check("rst_req_ready", req_ready, 0);
      check("rst_outputs", {rvalid, wready, resp_done, rlast}, 4'b0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_reset", req_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic req(input bit we, input logic [31:0] addr, input bit hold, output int k);
    bit ok = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    k = -1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1;
        k  = cyc;
        break;
      end
    end
    if (!ok) check("req_accept_timeout", 0, 1);
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input bit hold, output int k);
    int b;
    b = line_base(addr);
    req(1'b0, addr, hold, k);
    for (int i = 0; i < LW; i++) begin
      rexp_t e;
      e.data  = mdl[b + i];
      e.known = known[b + i];
      e.last  = (i == LW - 1);
      e.at    = k + LAT + 1 + i;
      rq.push_back(e);
    end
    dq.push_back(k + LAT + LW + 1);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [LW*32-1:0] dv,
                          input int stall_after, input int stall_len, input int abort_after);
    int k, b, j, first, t;
    bit stalled = 0;
    b = line_base(addr);
    req(1'b1, addr, 1'b0, k);
    if (abort_after < 0) dq.push_back(k + LAT + LW + 1 + stall_len);
    j = 0; first = -1; t = 0;
    wvalid = 1'b1;
    wdata  = dv[31:0];
    while (j < LW && t < 300) begin
      @(negedge clk);
      t++;
      if (wready && first < 0) first = cyc;
      if (wready) begin
        mdl[b + j]   = dv[j*32 +: 32];
        known[b + j] = 1;
        j++;
      end
      @(posedge clk); #1;
      if (j == abort_after) begin
        do_reset();
        return;
      end
      if (j == stall_after && stall_len > 0 && !stalled) begin
        stalled = 1;
        wvalid = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          check("wready_during_stall", wready, 1);
          @(posedge clk); #1;
        end
        wvalid = 1'b1;
      end
      if (j < LW) wdata = dv[j*32 +: 32];
    end
    wvalid = 1'b0;
    check("write_burst_timeout", (t < 300), 1);
    check("wready_first_cycle", 64'(first), 64'(k + LAT + 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k1, k2, kd;
    int lines [8];
    for (int i = 0; i < DEPTH; i++) known[i] = 0;

    @(posedge clk); #1;
    do_reset();

    // Basic write then read of line 0x40.
    do_write(32'h40, {32'h44, 32'h33, 32'h22, 32'h11}, -1, 0, -1);
    do_read(32'h40, 1'b0, kd);
    // Unaligned address inside the same line.
    do_read(32'h4C, 1'b0, kd);
    // 0x1040 aliases word 16 (byte 0x40) when the array holds 1024 words.
    do_write(32'h1040, {$urandom(), $urandom(), $urandom(), $urandom()}, -1, 0, -1);
    do_read(32'h40, 1'b0, kd);
    // Write stalled for 5 cycles after beat 1.
    do_write(32'h100, {32'hD4, 32'hC3, 32'hB2, 32'hA1}, 2, 5, -1);
    do_read(32'h100, 1'b0, kd);
    // Back-to-back reads with req_valid held high.
    do_write(32'h200, {$urandom(), $urandom(), $urandom(), $urandom()}, -1, 0, -1);
    do_read(32'h40, 1'b1, k1);
    do_read(32'h200, 1'b0, k2);
    check("back_to_back_accept", 64'(k2), 64'(k1 + LAT + LW + 2));
    // Reset after two beats of a write: first two words new, rest old.
    do_write(32'h80, {32'hD, 32'hC, 32'hB, 32'hA}, -1, 0, -1);
    do_read(32'h80, 1'b0, kd);
    do_write(32'h80, {32'h4, 32'h3, 32'h2, 32'h1}, -1, 0, 2);
    do_read(32'h80, 1'b0, kd);

    // Randomized mix over a handful of lines, including aliased high addresses.
    for (int i = 0; i < 8; i++) lines[i] = 32'h300 + i * 16;
    for (int i = 0; i < 8; i++)
      do_write(lines[i], {$urandom(), $urandom(), $urandom(), $urandom()}, -1, 0, -1);
    for (int n = 0; n < 24; n++) begin
      logic [31:0] a;
      a = 32'(lines[$urandom_range(0, 7)]) + 32'($urandom_range(0, 15))
          + (32'($urandom_range(0, 3)) << 12);
      if ($urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 1) == 1)
          do_write(a, {$urandom(), $urandom(), $urandom(), $urandom()},
                   int'($urandom_range(1, 3)), int'($urandom_range(1, 4)), -1);
        else
          do_write(a, {$urandom(), $urandom(), $urandom(), $urandom()}, -1, 0, -1);
      end else begin
        do_read(a, 1'b0, kd);
      end
    end

    for (int t = 0; t < 200 && (rq.size() != 0 || dq.size() != 0); t++) @(negedge clk);
    check("scoreboard_drained", 64'(rq.size() + dq.size()), 0);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
